mem_arbiter: RTL and testbench

Two-port arbiter sharing the single 256x8 memory between the `eightbit` CPU (port 0) and a second master such as a loader/DMA or debug port (port 1). Each port speaks the same req/ready protocol the CPU already uses toward memory; the arbiter serialises accesses, registers each transaction onto the memory side, and returns read data with a one-cycle ready pulse. Sits between `eightbit` and the memory model, so the CPU needs no changes.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/rr_pick2.sv | 17 +
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, default widths
// and port indices.
package mem_arb_pkg;

  localparam int unsigned DefaultAw = 8;
  localparam int unsigned DefaultDw = 8;

  localparam int unsigned P0 = 0;
  localparam int unsigned P1 = 1;

  typedef enum logic [1:0] {
    StIdle,
    StMem,
    StResp
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin chooser: a lone requester wins, a tie goes to the
// port that was not served last. last=1 means port 1 was served last.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win     = 2'b00;
    win[P0] = req[P0] & (~req[P1] | last);
    win[P1] = req[P1] & (~req[P0] | ~last);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises accesses from two req/ready masters onto a single memory port with
// round-robin arbitration; every output comes straight from a register.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = DefaultAw,
  parameter int unsigned DW = DefaultDw
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_ready,

  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_ready,

  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,

  output logic [1:0]    grant,
  output logic          busy
);

  arb_state_e    state_q;
  logic          last_q;
  logic [1:0]    win;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req  ({p1_req, p0_req}),
    .last (last_q),
    .win  (win)
  );

  always_comb begin
    sel_we    = p0_we;
    sel_addr  = p0_addr;
    sel_wdata = p0_wdata;
    if (win[P1]) begin
      sel_we    = p1_we;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;  // port 0 wins the first tie
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      p0_ready  <= 1'b0;
      p1_ready  <= 1'b0;
      grant     <= 2'b00;
      busy      <= 1'b0;
    end else begin
      p0_ready <= 1'b0;
      p1_ready <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|win) begin
            mem_req   <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            grant     <= win;
            last_q    <= win[P1];
            busy      <= 1'b1;
            state_q   <= StMem;
          end
        end
        StMem: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (grant[P1]) begin
              p1_rdata <= mem_rdata;
              p1_ready <= 1'b1;
            end else begin
              p0_rdata <= mem_rdata;
              p0_ready <= 1'b1;
            end
            state_q <= StResp;
          end
        end
        StResp: begin
          // One-cycle gap lets the served requester drop req before IDLE samples again.
          grant   <= 2'b00;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transfers plus reset, tie and fairness sequences,
// with per-port scoreboards fed at drive time and drained on each ready pulse.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [7:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
  logic [7:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       p0_ready, p1_ready, mem_req, mem_we, mem_ready, busy;
  logic [1:0] grant;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_rdata  (p0_rdata),
    .p0_ready  (p0_ready),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_rdata  (p1_rdata),
    .p1_ready  (p1_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Memory model: ready asserted 'lat' cycles after mem_req rises, write returns its data.
  logic [7:0] mem [256];
  logic       mem_init = 1'b1;
  int         lat = 0;
  int         wcnt = 0;

  assign mem_ready = mem_req && (wcnt >= lat);
  assign mem_rdata = mem_we ? mem_wdata : mem[mem_addr];

  always @(posedge clk) begin
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 224) ? 8'h01 : 8'(255 - i);
    end else if (mem_req && mem_ready && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  int checks = 0;
  int failures = 0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Scoreboards and monitor
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [1:0] glog[$];
  logic       r0_prev = 1'b0, r1_prev = 1'b0;
  logic [1:0] g_prev = 2'b00;
  int         n0 = 0, n1 = 0;

  always @(negedge clk) begin
    if (p0_ready) begin
      check("p0_ready_one_cycle", int'(r0_prev), 0);
      check("p0_ready_expected", int'(q0.size() != 0), 1);
      if (q0.size() != 0) check("p0_rdata", p0_rdata, q0.pop_front());
      n0 <= n0 + 1;
    end
    if (p1_ready) begin
      check("p1_ready_one_cycle", int'(r1_prev), 0);
      check("p1_ready_expected", int'(q1.size() != 0), 1);
      if (q1.size() != 0) check("p1_rdata", p1_rdata, q1.pop_front());
      n1 <= n1 + 1;
    end
    if (grant != 2'b00 && g_prev == 2'b00) glog.push_back(grant);
    r0_prev <= p0_ready;
    r1_prev <= p1_ready;
    g_prev  <= grant;
  end

  task automatic xfer(input int port, input logic we, input logic [7:0] addr,
                      input logic [7:0] wdata, input logic [7:0] exp, input int l);
    int  cyc;
    bit  seen;
    @(negedge clk);
    lat = l;
    if (port == 0) begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata; q0.push_back(exp);
    end else begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; q1.push_back(exp);
    end
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check("mem_req_on_grant", int'(mem_req), 1);
        check("mem_addr", mem_addr, addr);
        check("mem_we", int'(mem_we), int'(we));
        check("grant", grant, (port == 0) ? 1 : 2);
        check("busy", int'(busy), 1);
      end
      seen = (port == 0) ? p0_ready : p1_ready;
    end
    check("ready_latency", cyc, 2 + l);
    check("other_port_quiet", int'((port == 0) ? p1_ready : p0_ready), 0);
    check("mem_req_dropped", int'(mem_req), 0);
    if (we) check("mem_written", mem[addr], wdata);
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int         port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
    int         l;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int b0, b1, k0, k1, cyc;

    vecs[0] = '{0, 1'b0, 8'hE0, 8'h00, 8'h01, 0};
    vecs[1] = '{1, 1'b1, 8'h10, 8'h5A, 8'h5A, 0};
    vecs[2] = '{0, 1'b0, 8'h10, 8'h00, 8'h5A, 1};
    vecs[3] = '{1, 1'b0, 8'h33, 8'h00, 8'hCC, 0};
    vecs[4] = '{0, 1'b1, 8'hFF, 8'h00, 8'h00, 2};
    vecs[5] = '{1, 1'b0, 8'hFF, 8'h00, 8'h00, 1};
    vecs[6] = '{0, 1'b0, 8'h00, 8'h00, 8'hFF, 3};
    vecs[7] = '{1, 1'b1, 8'h80, 8'hC3, 8'hC3, 0};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_mem_req", int'(mem_req), 0);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_ready", int'({p1_ready, p0_ready}), 0);
    check("rst_rdata", int'({p1_rdata, p0_rdata}), 0);
    check("rst_grant", grant, 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      xfer(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].l);

    // Reset while an access is stalled in MEM: abandoned, no ready pulse
    lat = 5;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h33;
    repeat (2) @(negedge clk);
    check("pre_rst_in_mem", int'(mem_req), 1);
    b0 = n0;
    rst = 1'b1;
    #1;
    check("mid_rst_mem_req", int'(mem_req), 0);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'(p0_ready), 0);
    p0_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lat = 0;
    repeat (3) @(negedge clk);
    check("no_ready_after_abort", n0, b0);

    // Tie straight out of reset: port 0 first, then port 1
    glog.delete();
    b0 = n0;
    b1 = n1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h33; q0.push_back(8'hCC);
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h80; q1.push_back(8'hC3);
    cyc = 0;
    while ((p0_req || p1_req) && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (p0_ready) p0_req = 1'b0;
      if (p1_ready) p1_req = 1'b0;
    end
    check("tie_done_in_time", int'(cyc < 30), 1);
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (3) @(negedge clk);
    check("tie_grant_count", glog.size(), 2);
    if (glog.size() >= 2) begin
      check("tie_first_grant", glog[0], 1);
      check("tie_second_grant", glog[1], 2);
    end
    check("tie_p0_completions", n0 - b0, 1);
    check("tie_p1_completions", n1 - b1, 1);

    // Fairness: both hold req for 8 accesses, grants must alternate
    glog.delete();
    b0 = n0;
    b1 = n1;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(8'hC3);
      q1.push_back(8'h5A);
    end
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h80;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h10;
    k0 = 0;
    k1 = 0;
    cyc = 0;
    while (!(k0 == 4 && k1 == 4) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (p0_ready) k0++;
      if (p1_ready) k1++;
    end
    check("fair_done_in_time", int'(cyc < 100), 1);
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (3) @(negedge clk);
    check("fair_grant_count", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++)
      check("fair_alternation", glog[i], (i % 2 == 0) ? 1 : 2);
    check("fair_p0_completions", n0 - b0, 4);
    check("fair_p1_completions", n1 - b1, 4);
    check("scoreboards_drained", q0.size() + q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
